// File: rtl/chacha_block_core.sv
// ChaCha block function core: one column or diagonal round per cycle, then a
// final feed-forward addition of the original matrix into the keystream output.
module chacha_block_core #(
    parameter int unsigned ROUNDS = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0][3:0][31:0]   state_in,
    output logic                    busy,
    output logic                    done,
    output logic [3:0][3:0][31:0]   ks_out
);

    localparam int unsigned CW = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        ADD
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           rnd_cnt_q, rnd_cnt_d;
    logic [3:0][3:0][31:0]   orig_q, orig_d;
    logic [3:0][3:0][31:0]   work_q, work_d;
    logic [3:0][3:0][31:0]   ks_q, ks_d;
    logic                    done_q, done_d;
    logic [3:0][3:0][31:0]   round_res;

    function automatic logic [127:0] quarter_round(
        input logic [31:0] a_in,
        input logic [31:0] b_in,
        input logic [31:0] c_in,
        input logic [31:0] d_in
    );
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // Lane q always starts at word q; odd rounds shift the b/c/d columns by
    // 1/2/3 to walk the diagonals instead of the columns.
    always_comb begin
        logic        diag;
        logic [3:0]  ia, ib, ic, id;
        logic [127:0] qr;
        round_res = work_q;
        diag      = rnd_cnt_q[0];
        for (int unsigned q = 0; q < 4; q++) begin
            ia = {2'd0, 2'(q)};
            ib = {2'd1, diag ? 2'(q + 1) : 2'(q)};
            ic = {2'd2, diag ? 2'(q + 2) : 2'(q)};
            id = {2'd3, diag ? 2'(q + 3) : 2'(q)};
            qr = quarter_round(work_q[ia[3:2]][ia[1:0]], work_q[ib[3:2]][ib[1:0]],
                               work_q[ic[3:2]][ic[1:0]], work_q[id[3:2]][id[1:0]]);
            round_res[ia[3:2]][ia[1:0]] = qr[127:96];
            round_res[ib[3:2]][ib[1:0]] = qr[95:64];
            round_res[ic[3:2]][ic[1:0]] = qr[63:32];
            round_res[id[3:2]][id[1:0]] = qr[31:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        rnd_cnt_d = rnd_cnt_q;
        orig_d    = orig_q;
        work_d    = work_q;
        ks_d      = ks_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    orig_d    = state_in;
                    work_d    = state_in;
                    rnd_cnt_d = '0;
                    state_d   = ROUND;
                end
            end
            ROUND: begin
                work_d    = round_res;
                rnd_cnt_d = rnd_cnt_q + 1'b1;
                if (rnd_cnt_q == CW'(ROUNDS - 1)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int unsigned r = 0; r < 4; r++) begin
                    for (int unsigned c = 0; c < 4; c++) begin
                        ks_d[2'(r)][2'(c)] = work_q[2'(r)][2'(c)] + orig_q[2'(r)][2'(c)];
                    end
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rnd_cnt_q <= '0;
            orig_q    <= '0;
            work_q    <= '0;
            ks_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rnd_cnt_q <= rnd_cnt_d;
            orig_q    <= orig_d;
            work_q    <= work_d;
            ks_q      <= ks_d;
            done_q    <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign ks_out = ks_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench for chacha_block_core: independent RFC 8439 model feeds a
// scoreboard queue; each scenario task checks latency, pulses and results inline.
module tb_chacha_block_core;

    localparam int ROUNDS = 20;
    localparam int LAT    = ROUNDS + 2;

    typedef logic [3:0][3:0][31:0] blk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    blk_t state_in = '0;
    logic busy;
    logic done;
    blk_t ks_out;

    int total = 0;
    int bad = 0;
    blk_t sb_q[$];

    chacha_block_core #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .state_in (state_in),
        .busy     (busy),
        .done     (done),
        .ks_out   (ks_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        a += b; d ^= a; d = rotl(d, 16);
        c += d; b ^= c; b = rotl(b, 12);
        a += b; d ^= a; d = rotl(d, 8);
        c += d; b ^= c; b = rotl(b, 7);
        return {a, b, c, d};
    endfunction

    function automatic blk_t model(input blk_t s);
        logic [31:0] x[16];
        logic [31:0] o[16];
        blk_t res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                x[4'(r * 4 + c)] = s[2'(r)][2'(c)];
        o = x;
        for (int k = 0; k < ROUNDS / 2; k++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[2'(r)][2'(c)] = x[4'(r * 4 + c)] + o[4'(r * 4 + c)];
        return res;
    endfunction

    function automatic blk_t rfc_state(input logic [31:0] cnt);
        blk_t s;
        s[0] = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        s[1] = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
        s[2] = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110};
        s[3] = {32'h00000000, 32'h4a000000, 32'h09000000, cnt};
        return s;
    endfunction

    function automatic blk_t rand_blk();
        blk_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[2'(r)][2'(c)] = $urandom;
        return s;
    endfunction

    // Drives one start pulse; returns at the first sample point after the accept edge.
    task automatic launch(input blk_t s);
        @(negedge clk);
        state_in = s;
        start    = 1'b1;
        sb_q.push_back(model(s));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, inout int n, output bit seen);
        seen = 1'b0;
        while (n < budget && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++;
        if (ks_out !== '0) begin bad++; $display("FAIL reset_ks got=%h want=0", ks_out); end
    endtask

    task automatic test_qr_model();
        logic [127:0] got;
        got = qr(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567);
        total++;
        if (got !== 128'hea2a92f4_cb1cf8ce_4581472e_5881c4bb) begin
            bad++;
            $display("FAIL qr_unit got=%h want=ea2a92f4cb1cf8ce4581472e5881c4bb", got);
        end
    endtask

    task automatic test_rfc_vector();
        int n = 1;
        bit seen;
        blk_t exp_b;
        launch(rfc_state(32'd1));
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rfc_busy_t1 got=%b want=1", busy); end
        wait_done(40, n, seen);
        total++;
        if (!seen || n != LAT) begin bad++; $display("FAIL rfc_latency got=%0d seen=%b want=%0d", n, seen, LAT); end
        exp_b = sb_q.pop_front();
        total++;
        if (ks_out !== exp_b) begin bad++; $display("FAIL rfc_block got=%h want=%h", ks_out, exp_b); end
        total++;
        if (ks_out[0][0] !== 32'he4e7f110) begin bad++; $display("FAIL rfc_w00 got=%h want=e4e7f110", ks_out[0][0]); end
        total++;
        if (ks_out[0][1] !== 32'h15593bd1) begin bad++; $display("FAIL rfc_w01 got=%h want=15593bd1", ks_out[0][1]); end
        total++;
        if (ks_out[3][3] !== 32'h4e3c50a2) begin bad++; $display("FAIL rfc_w33 got=%h want=4e3c50a2", ks_out[3][3]); end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rfc_after_done got done=%b busy=%b want 0 0", done, busy);
        end
        state_in = rand_blk();
        repeat (5) @(negedge clk);
        total++;
        if (ks_out !== exp_b) begin bad++; $display("FAIL ks_hold got=%h want=%h", ks_out, exp_b); end
    endtask

    task automatic test_busy_ignore();
        int n = 1;
        int dones = 0;
        int first_n = 0;
        blk_t got = '0;
        blk_t exp_b;
        launch(rfc_state(32'd1));
        while (n < 60) begin
            @(negedge clk);
            n++;
            start = (n == 5 || n == 10);
            if (n == 5) state_in = rand_blk();
            if (done) begin
                dones++;
                if (dones == 1) begin first_n = n; got = ks_out; end
            end
        end
        start = 1'b0;
        exp_b = sb_q.pop_front();
        total++;
        if (dones != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        total++;
        if (first_n != LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", first_n, LAT); end
        total++;
        if (got !== exp_b) begin bad++; $display("FAIL ignore_block got=%h want=%h", got, exp_b); end
    endtask

    task automatic test_reset_abort();
        int n = 1;
        int dones = 0;
        bit seen;
        blk_t exp_b;
        launch(rfc_state(32'd1));
        exp_b = sb_q.pop_back();
        while (n < 8) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++;
        if (ks_out !== '0) begin bad++; $display("FAIL abort_ks got=%h want=0", ks_out); end
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        total++;
        if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        launch(rfc_state(32'd1));
        n = 1;
        wait_done(40, n, seen);
        total++;
        if (!seen || n != LAT) begin bad++; $display("FAIL abort_restart_latency got=%0d seen=%b want=%0d", n, seen, LAT); end
        exp_b = sb_q.pop_front();
        total++;
        if (ks_out !== exp_b) begin bad++; $display("FAIL abort_restart_block got=%h want=%h", ks_out, exp_b); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int dones = 0;
        int d1 = 0;
        int d2 = 0;
        blk_t s2 = rfc_state(32'd2);
        blk_t exp_b;
        @(negedge clk);
        state_in = rfc_state(32'd1);
        start = 1'b1;
        sb_q.push_back(model(rfc_state(32'd1)));
        while (n < 70) begin
            @(negedge clk);
            n++;
            if (n == 10) state_in = rand_blk();
            if (n == 20) state_in = s2;
            if (n == 23) begin start = 1'b0; state_in = rand_blk(); end
            if (n == 30) state_in = '0;
            if (done) begin
                dones++;
                if (sb_q.size() > 0) exp_b = sb_q.pop_front();
                else exp_b = 'x;
                total++;
                if (ks_out !== exp_b) begin
                    bad++; $display("FAIL b2b_block%0d got=%h want=%h", dones, ks_out, exp_b);
                end
                if (dones == 1) begin d1 = n; sb_q.push_back(model(s2)); end
                else d2 = n;
            end
        end
        start = 1'b0;
        total++;
        if (dones != 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", dones); end
        total++;
        if (d1 != LAT || d2 != 2 * LAT) begin
            bad++; $display("FAIL b2b_timing got=%0d,%0d want=%0d,%0d", d1, d2, LAT, 2 * LAT);
        end
    endtask

    task automatic test_all_zero();
        int n = 1;
        bit seen;
        blk_t exp_b;
        launch('0);
        wait_done(40, n, seen);
        total++;
        if (!seen || n != LAT) begin bad++; $display("FAIL zero_latency got=%0d seen=%b want=%0d", n, seen, LAT); end
        exp_b = sb_q.pop_front();
        total++;
        if (ks_out !== '0 || ks_out !== exp_b) begin bad++; $display("FAIL zero_block got=%h want=0", ks_out); end
    endtask

    initial begin
        test_reset();
        test_qr_model();
        test_rfc_vector();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_all_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chacha_block_core.md
CHACHA_BLOCK_CORE -- requirements
Module: chacha_block_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 20, giving the total number of column plus diagonal rounds; it shall be even and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to compute one block; sampled only in IDLE.
REQ-005 SHALL have port state_in, input, 4x4 array of 32-bit words: initial ChaCha matrix, [row][col], from the upstream state builder; sampled on the accepted start edge.
REQ-006 SHALL have port busy, output, 1 bit: high while a block is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when ks_out is valid.
REQ-008 SHALL have port ks_out, output, 4x4 array of 32-bit words: keystream block, same [row][col] layout as state_in.

Function
REQ-009 SHALL implement FSM states IDLE, ROUND and ADD.
REQ-010 In IDLE with start=1, the block SHALL copy state_in into both orig and work registers, clear rnd_cnt, and enter ROUND.
REQ-011 Each ROUND cycle SHALL apply four quarter-rounds in parallel to work.
- Column round on even rnd_cnt: (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
- Diagonal round on odd rnd_cnt: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
- Word index = row*4+col.
REQ-012 The quarter-round SHALL be as defined in RFC 8439:
- a+=b; d^=a; d<<<=16
- c+=d; b^=c; b<<<=12
- a+=b; d^=a; d<<<=8
- c+=d; b^=c; b<<<=7
- All additions mod 2^32; rotations are left rotations.
REQ-013 rnd_cnt SHALL increment each ROUND cycle; when rnd_cnt==ROUNDS-1, the next state SHALL be ADD.
REQ-014 The ADD cycle SHALL register ks_out[i] = work[i] + orig[i] mod 2^32 for all 16 words, assert done for the following cycle, and return to IDLE.
REQ-015 Latency: start accepted at cycle T SHALL give done=1 at cycle T+ROUNDS+2 (T+22 by default).
REQ-016 busy SHALL be high in ROUND and ADD (cycles T+1..T+ROUNDS+1) and low in IDLE.
REQ-017 done SHALL be high for exactly one cycle per accepted start.
REQ-018 ks_out SHALL hold its value until the next ADD cycle and SHALL be unaffected by state_in changes.
REQ-019 start while busy=1 SHALL be ignored, with no queuing.
REQ-020 start in the cycle done=1 SHALL be accepted; back-to-back period is ROUNDS+2 cycles.
REQ-021 state_in SHALL be ignored except on the accepted start edge; upstream may clear or reload its matrix while busy.

Reset
REQ-022 rst=1 SHALL force, on the next edge:
- FSM to IDLE
- busy=0, done=0
- rnd_cnt=0
- ks_out, orig and work to all zero
REQ-023 rst SHALL take priority over start and over any in-progress computation.
REQ-024 rst mid-operation SHALL abort the block; no done pulse shall follow for the aborted request.

Verification
REQ-025 Quarter-round unit check: a=11111111 b=01020304 c=9b8d6f43 d=01234567 -> a=ea2a92f4 b=cb1cf8ce c=4581472e d=5881c4bb.
REQ-026 RFC 8439 2.3.2 vector, single block:
- Stimulus: key 00..1f, nonce 00000009 0000004a 00000000, block count 1, constants 61707865 3320646e 79622d32 6b206574.
- Required response: done at T+22; ks_out[0][0]=e4e7f110, ks_out[0][1]=15593bd1, ks_out[3][3]=4e3c50a2.
REQ-027 start pulsed at T+5 and T+10 during busy -> exactly one done, at T+22; ks_out equals the single-block result.
REQ-028 rst asserted at T+8 -> busy=0 and ks_out=0 from T+9; no done within 30 cycles; a new start then yields the correct vector 22 cycles later.
REQ-029 Back-to-back blocks:
- Stimulus: start held high with block count 1 then 2; state_in changed mid-block.
- Required response: done at T+22 and T+44; each result corresponds to state_in sampled at its accept edge only.
REQ-030 All-zero state_in -> ks_out all zero, because the quarter-round maps zero to zero; done at T+22.
